// File: rtl/pwm_capture.sv
// pwm_capture: measures a servo-style PWM input and recovers magnitude = high_time * DUTY_FACTOR / period.
module pwm_capture #(
  parameter int CNT_W       = 22,
  parameter int DUTY_FACTOR = 80000,
  parameter int MIN_PERIOD  = 64,
  parameter int TIMEOUT     = 2000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pulseIn,
  output logic [16:0] magnitude,
  output logic        magValid,
  output logic        signalLost,
  output logic        glitchErr
);
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CMAX = '1;
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  state_t state_q, state_d;
  logic [2:0] sync_q, sync_d;
  logic rise_q, rise_d, fall_q, fall_d;
  logic [CNT_W-1:0] high_q, high_d, per_q, per_d, dvs_q, dvs_d, rem_q, rem_d;
  logic [IW-1:0] idle_q, idle_d;
  logic busy_q, busy_d;
  logic [5:0] it_q, it_d;
  logic [39:0] dvd_q, dvd_d;
  logic [16:0] magnitude_q, magnitude_d;
  logic mag_valid_q, mag_valid_d, lost_q, lost_d, glitch_err_q, glitch_err_d, pend_q, pend_d;
  logic start, glitch, done, sub;
  logic [CNT_W:0] rem_sh, diff;
  always_comb begin
    sync_d = {sync_q[1:0], pulseIn};
    rise_d = sync_q[1] & ~sync_q[2];
    fall_d = ~sync_q[1] & sync_q[2];
    state_d = state_q;
    high_d = (state_q == HIGH && !fall_q && high_q != CMAX) ? high_q + 1'b1 : high_q;
    per_d = (state_q != IDLE && per_q != CMAX) ? per_q + 1'b1 : per_q;
    idle_d = (idle_q == IW'(TIMEOUT)) ? idle_q : idle_q + 1'b1;
    lost_d = lost_q;
    start = 1'b0;
    glitch = 1'b0;
    // A rising edge outranks a timeout landing on the same cycle
    if (rise_q) begin
      start = state_q == LOW && per_q >= CNT_W'(MIN_PERIOD) && !busy_q;
      glitch = state_q == LOW && per_q < CNT_W'(MIN_PERIOD);
      state_d = HIGH;
      per_d = CNT_W'(1);
      high_d = CNT_W'(1);
      idle_d = '0;
    end else if (idle_q == IW'(TIMEOUT)) begin
      state_d = IDLE;
      lost_d = 1'b1;
    end else if (state_q == HIGH && fall_q) begin
      state_d = LOW;
    end
    rem_sh = {rem_q, dvd_q[39]};
    diff = rem_sh - {1'b0, dvs_q};
    sub = rem_sh >= {1'b0, dvs_q};
    done = busy_q && it_q == 6'd39;
    busy_d = busy_q && !done;
    it_d = busy_q ? it_q + 1'b1 : it_q;
    rem_d = busy_q ? (sub ? diff[CNT_W-1:0] : rem_sh[CNT_W-1:0]) : rem_q;
    dvd_d = busy_q ? {dvd_q[38:0], sub} : dvd_q;
    dvs_d = dvs_q;
    if (start) begin
      busy_d = 1'b1;
      it_d = '0;
      rem_d = '0;
      dvd_d = 40'(high_q) * 40'(DUTY_FACTOR);
      dvs_d = per_q;
    end
    mag_valid_d = done;
    magnitude_d = done ? dvd_d[16:0] : magnitude_q;
    lost_d = done ? 1'b0 : lost_d;
    // A glitch colliding with magValid is held back one cycle
    glitch_err_d = (glitch | pend_q) & ~done;
    pend_d = (glitch | pend_q) & done;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sync_q <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      high_q <= '0;
      per_q <= '0;
      idle_q <= '0;
      busy_q <= 1'b0;
      it_q <= '0;
      rem_q <= '0;
      dvd_q <= '0;
      dvs_q <= '0;
      magnitude_q <= '0;
      mag_valid_q <= 1'b0;
      lost_q <= 1'b1;
      glitch_err_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q <= sync_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      high_q <= high_d;
      per_q <= per_d;
      idle_q <= idle_d;
      busy_q <= busy_d;
      it_q <= it_d;
      rem_q <= rem_d;
      dvd_q <= dvd_d;
      dvs_q <= dvs_d;
      magnitude_q <= magnitude_d;
      mag_valid_q <= mag_valid_d;
      lost_q <= lost_d;
      glitch_err_q <= glitch_err_d;
      pend_q <= pend_d;
    end
  end
  assign magnitude = magnitude_q;
  assign magValid = mag_valid_q;
  assign signalLost = lost_q;
  assign glitchErr = glitch_err_q;
endmodule
